// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, FSM states,
// instruction classes and datapath select values.
package ctrl_pkg;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BLEU = 6'b010000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_MEM, CLS_BR, CLS_JMP, CLS_ILL
  } op_class_e;

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_NOR    = 5'd1;
  localparam logic [4:0] ALU_ADD    = 5'd2;
  localparam logic [4:0] ALU_CMPLEU = 5'd3;
  localparam logic [4:0] ALU_ROL    = 5'd4;
  localparam logic [4:0] ALU_ROR    = 5'd5;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_JUMP   = 2'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier and ALU operation lookup; one copy serves both the
// DECODE dispatch and the execute/writeback states.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_e  op_class,
  output logic [4:0] alu_ctl
);

  always_comb begin
    op_class = CLS_ILL;
    alu_ctl  = ALU_AND;
    case (opcode)
      OP_AND:  begin op_class = CLS_R;   alu_ctl = ALU_AND; end
      OP_NOR:  begin op_class = CLS_R;   alu_ctl = ALU_NOR; end
      OP_NOT:  begin op_class = CLS_R;   alu_ctl = ALU_NOR; end
      OP_ROLV: begin op_class = CLS_R;   alu_ctl = ALU_ROL; end
      OP_RORV: begin op_class = CLS_R;   alu_ctl = ALU_ROR; end
      OP_NORI: begin op_class = CLS_I;   alu_ctl = ALU_NOR; end
      OP_LW,
      OP_SW:   begin op_class = CLS_MEM; alu_ctl = ALU_ADD; end
      OP_BLEU: begin op_class = CLS_BR;  alu_ctl = ALU_CMPLEU; end
      OP_JR,
      OP_JAL:  op_class = CLS_JMP;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch,
// decode, execute, memory and writeback over a shared req/ready memory port.
//
// state    | meaning
// FETCH    | request instruction word (when run or a fetch is pending)
// DECODE   | latch opcode, dispatch by instruction class
// EXEC_R   | register-register ALU op
// EXEC_I   | nori with zero-extended immediate
// ADDR     | effective address for lw/sw
// MEM      | data access, held until mem_ready
// WB       | register-file write, retire
// BRANCH   | bleu compare and conditional PC load, retire
// JUMP     | jr/jal PC load (jal links), retire
// TRAP     | illegal opcode, absorbing until reset
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [5:0]          opcode,
  input  logic                cmp_le,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [4:0]          alu_ctl,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  state_e     state, nxt;
  logic [5:0] op_q;
  logic       fetch_pend, pend_nxt;
  logic       retire;
  op_class_e  dec_class;
  logic [4:0] dec_alu;

  ctrl_decode u_decode (
    .opcode   ((state == S_DECODE) ? opcode : op_q),
    .op_class (dec_class),
    .alu_ctl  (dec_alu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      op_q       <= '0;
      fetch_pend <= 1'b0;
      retired    <= '0;
    end else begin
      state      <= nxt;
      fetch_pend <= pend_nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    nxt        = state;
    pend_nxt   = 1'b0;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_ctl    = ALU_AND;
    alu_src_b  = SRCB_RT;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALU;
    trap       = 1'b0;
    case (state)
      // a started fetch keeps requesting even if run drops mid-wait
      S_FETCH: if (run || fetch_pend) begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else begin
          pend_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        case (dec_class)
          CLS_R:   nxt = S_EXEC_R;
          CLS_I:   nxt = S_EXEC_I;
          CLS_MEM: nxt = S_ADDR;
          CLS_BR:  nxt = S_BRANCH;
          CLS_JMP: nxt = S_JUMP;
          default: nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_ctl = dec_alu;
        nxt     = S_WB;
      end
      S_EXEC_I: begin
        alu_ctl   = ALU_NOR;
        alu_src_b = SRCB_ZEXT;
        nxt       = S_WB;
      end
      S_ADDR: begin
        alu_ctl   = ALU_ADD;
        alu_src_b = SRCB_SEXT;
        nxt       = S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (dec_class == CLS_R) ? DST_RD : DST_RT;
        mem_to_reg = (op_q == OP_LW) ? WB_MEM : WB_ALU;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctl  = ALU_CMPLEU;
        pc_write = cmp_le;
        pc_src   = PC_BRANCH;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
        if (op_q == OP_JAL) begin
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = WB_PC;
        end else begin
          pc_src = PC_REG;
        end
      end
      S_TRAP: trap = 1'b1;
      default: nxt = S_FETCH;
    endcase
    // reset silences every output at once, including an in-flight mem_req
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      alu_ctl    = ALU_AND;
      alu_src_b  = SRCB_RT;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      mem_to_reg = WB_ALU;
      trap       = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the processor datapath. Replaces per-instruction combinational decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It shares the single memory port between instruction fetch and load/store over a req/ready handshake. It sits beside the datapath, reads the opcode field of the instruction register, and drives every datapath enable and select.

## Interface
Parameters:
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- run  in  1  permits a new fetch; sampled only in FETCH
- opcode  in  6  ins[31:26] from instruction register; valid from DECODE onward
- cmp_le  in  1  datapath result rs <= rt (unsigned); valid in BRANCH
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  0 = memory address from PC, 1 = from ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = register (jr), 3 = jump target (jal)
- alu_ctl  out  5  ALU operation, encoding from package
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = zero-extended immediate
- reg_write  out  1  register-file write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  0 = ALU, 1 = memory data, 2 = PC (link)
- trap  out  1  sticky illegal-opcode flag
- retired  out  RETIRE_W  count of completed instructions

## Operation
- Opcodes: and 100000, nor 100110, not 000100 (nor with $0), rolv 000000, rorv 000010, nori 001110, lw 100011, sw 101011, jr 001000, jal 000011, bleu 010000; all others are illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM, WB, BRANCH, JUMP, TRAP.
- FETCH: if run, mem_req=1, iord=0. When mem_ready: ir_write=1, pc_write=1, pc_src=0; go to DECODE. If run=0: all outputs 0; stay.
- DECODE: latch opcode into op_q.
  - R-type (and, nor, not, rolv, rorv) goes to EXEC_R.
  - nori goes to EXEC_I.
  - lw and sw go to ADDR.
  - bleu goes to BRANCH.
  - jr and jal go to JUMP.
  - Illegal goes to TRAP.
- EXEC_R: alu_ctl per op_q, alu_src_b=0; go to WB.
- EXEC_I: alu_ctl=NOR, alu_src_b=3; go to WB.
- ADDR: alu_ctl=ADD, alu_src_b=2; go to MEM.
- MEM: mem_req=1, iord=1, mem_we=(op_q==sw). When mem_ready: lw goes to WB; sw retires and goes to FETCH.
- WB: reg_write=1. reg_dst=1 for R-type, 0 for nori and lw. mem_to_reg=1 for lw, else 0. Retires; go to FETCH.
- BRANCH: alu_ctl=CMPLEU, alu_src_b=0; pc_write=cmp_le, pc_src=1. Retires; go to FETCH.
- JUMP: pc_write=1, pc_src=2 for jr, 3 for jal. jal also asserts reg_write=1, reg_dst=2, mem_to_reg=2. Retires; go to FETCH.
- TRAP: trap=1, all other outputs 0. Absorbing state; left only by reset.
- retired increments by 1 on each retire event and wraps modulo 2^RETIRE_W.

## Timing
- Reset: state=FETCH, op_q=0, retired=0, trap=0. All outputs are 0 while reset is asserted.
- ir_write, pc_write (FETCH) and the MEM exit are Mealy on mem_ready. All other outputs are decoded from registered state and op_q.
- Handshake: once mem_req rises, it and iord/mem_we stay stable until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Zero-wait latency: R-type/nori 4 cycles, lw 5, sw 4, bleu 3, jr/jal 3. Each memory wait cycle adds 1.
- run=0 only blocks the next fetch. An instruction already past FETCH completes.
- Reset asserted during MEM or FETCH wait drops mem_req immediately (asynchronous). The partial access is abandoned.

## Structure
- Package ctrl_pkg holds:
  - opcode constants
  - state enum
  - alu_ctl encodings: AND=0, NOR=1, ADD=2, CMPLEU=3, ROL=4, ROR=5
  - pc_src, alu_src_b, reg_dst and mem_to_reg encodings
- One sub-module, ctrl_decode: combinational opcode-to-class and alu_ctl lookup, shared by DECODE and the execute states.
- The FSM, op_q and retired counter live in the top level.

## Test plan
- and, zero-wait memory, run=1: states FETCH, DECODE, EXEC_R, WB; reg_write=1 with reg_dst=1 in cycle 4; retired=1.
- lw with mem_ready delayed 3 cycles in MEM: mem_req, iord=1 and mem_we=0 held 4 cycles; WB has mem_to_reg=1, reg_dst=0; total 8 cycles.
- bleu with cmp_le=1 then cmp_le=0: pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; both retire.
- jal: JUMP cycle shows pc_write=1, pc_src=3, reg_write=1, reg_dst=2, mem_to_reg=2.
- Opcode 111111: TRAP entered after DECODE; trap=1 stays set for 20 cycles; no mem_req; retired unchanged; reset clears it.
- Reset pulse mid-MEM of sw, then run=0: mem_req drops in the same cycle; state FETCH; no mem_req until run=1.
